// File: rtl/frame_addr_gen.sv
// Multi-buffer frame address generator: walks a byte address through NUM_BUFS frame buffers.
// Define FRAME_ADDR_GEN_READ_LOCK_EN to skip the buffer currently held by the reader.
module frame_addr_gen #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       NUM_BUFS   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0F80_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 32'h0040_0000,
    parameter int unsigned       STEP       = 4,
    parameter int unsigned       IDX_W      = $clog2(NUM_BUFS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              increment,
    input  logic              switch,
    input  logic              rd_lock,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  buf_idx,
    output logic              done_valid,
    output logic [IDX_W-1:0]  done_idx,
    output logic              done_ovf,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned     OFF_W      = $clog2(BUF_STRIDE) + 1;
    localparam logic [ADDR_W:0] STRIDE_EXT = {1'b0, BUF_STRIDE};
    localparam logic [ADDR_W:0] STEP_EXT   = (ADDR_W+1)'(STEP);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUFS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              ovf_q, ovf_d;
    logic              done_valid_q, done_valid_d;
    logic [IDX_W-1:0]  done_idx_q, done_idx_d;
    logic              done_ovf_q, done_ovf_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [IDX_W-1:0]  nxt_idx;
    logic [ADDR_W:0]   off_inc;
    logic              inc_fits;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (i == LAST_IDX) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] buf_base(input logic [IDX_W-1:0] i);
        return BASE_ADDR + ADDR_W'(i) * BUF_STRIDE;
    endfunction

    // Offset math is done one bit wider than the address so the limit test cannot wrap.
    assign off_inc  = (ADDR_W+1)'(off_q) + STEP_EXT;
    assign inc_fits = (off_inc < STRIDE_EXT);

    always_comb begin
        nxt_idx = idx_inc(buf_idx_q);
`ifdef FRAME_ADDR_GEN_READ_LOCK_EN
        // NUM_BUFS >= 3 guarantees the second hop never lands back on the current buffer.
        if (rd_lock && (nxt_idx == rd_idx)) begin
            nxt_idx = idx_inc(nxt_idx);
        end
`endif
    end

`ifndef FRAME_ADDR_GEN_READ_LOCK_EN
    logic unused_rd;
    assign unused_rd = ^{rd_lock, rd_idx};
`endif

    always_comb begin
        addr_d       = addr_q;
        buf_idx_d    = buf_idx_q;
        off_d        = off_q;
        ovf_d        = ovf_q;
        done_valid_d = 1'b0;
        done_idx_d   = done_idx_q;
        done_ovf_d   = done_ovf_q;
        frame_cnt_d  = frame_cnt_q;

        if (switch) begin
            // A same-cycle increment is dropped but its overflow still marks the frame.
            buf_idx_d    = nxt_idx;
            off_d        = '0;
            addr_d       = buf_base(nxt_idx);
            done_valid_d = 1'b1;
            done_idx_d   = buf_idx_q;
            done_ovf_d   = ovf_q | (increment & ~inc_fits);
            ovf_d        = 1'b0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end else if (increment) begin
            if (inc_fits) begin
                off_d  = OFF_W'(off_inc);
                addr_d = addr_q + ADDR_W'(STEP);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q       <= BASE_ADDR;
            buf_idx_q    <= '0;
            off_q        <= '0;
            ovf_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_idx_q   <= LAST_IDX;
            done_ovf_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            buf_idx_q    <= buf_idx_d;
            off_q        <= off_d;
            ovf_q        <= ovf_d;
            done_valid_q <= done_valid_d;
            done_idx_q   <= done_idx_d;
            done_ovf_q   <= done_ovf_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign addr       = addr_q;
    assign buf_idx    = buf_idx_q;
    assign done_valid = done_valid_q;
    assign done_idx   = done_idx_q;
    assign done_ovf   = done_ovf_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/frame_addr_gen.md
# frame_addr_gen

Parametrised multi-buffer frame address generator for the DMA writer path. It produces the byte address for each pixel word written to DRAM and rotates through `NUM_BUFS` equally spaced frame buffers on each frame boundary. On every rotation it reports which buffer was just completed and whether that frame overran its buffer. With the read-lock feature compiled in, it also skips the buffer the display/readout side currently holds.

## Interface
Parameters:
- `ADDR_W`, 32, address width in bits.
- `NUM_BUFS`, 4, number of frame buffers (≥2; ≥3 when `FRAME_ADDR_GEN_READ_LOCK_EN` is defined).
- `BASE_ADDR`, 32'h0F80_0000, byte address of buffer 0.
- `BUF_STRIDE`, 32'h0040_0000, bytes per buffer; buffer n base = `BASE_ADDR + n*BUF_STRIDE`.
- `STEP`, 4, bytes added per increment; `BUF_STRIDE` must be a multiple of `STEP`.
- `IDX_W`, `$clog2(NUM_BUFS)`, buffer index width (derived; do not override).

Ports:
- `sys_clk` in 1: clock; all logic is on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `increment` in 1: advance address by `STEP`.
- `switch` in 1: frame end; rotate to the next buffer.
- `rd_lock` in 1: reader holds buffer `rd_idx`.
- `rd_idx` in `IDX_W`: buffer index held by the reader.
- `addr` out `ADDR_W`: current write byte address.
- `buf_idx` out `IDX_W`: buffer currently being written.
- `done_valid` out 1: one-cycle pulse when a buffer completes.
- `done_idx` out `IDX_W`: index of the last completed buffer.
- `done_ovf` out 1: the completed frame hit its buffer limit.
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0.

## Operation
- Internal state: `buf_idx`, byte offset `off` (width `$clog2(BUF_STRIDE)+1`), sticky `ovf`. `addr` is a register equal to `BASE_ADDR + buf_idx*BUF_STRIDE + off`.
- `increment` (with `switch` low):
  - If `off + STEP < BUF_STRIDE`: `off += STEP` and `addr += STEP`.
  - Otherwise: `addr` and `off` hold and `ovf` is set. The address never leaves the buffer.
- `switch`:
  - Next index `nxt = (buf_idx + 1) mod NUM_BUFS`. The lock-skip rule under Configuration may modify `nxt`.
  - `buf_idx <= nxt`, `off <= 0`, `addr <=` base of `nxt`.
  - `done_idx <=` old `buf_idx`, `done_ovf <=` `ovf` (or the overflow produced by a same-cycle increment), `done_valid <= 1` for one cycle.
  - `ovf <= 0`; `frame_cnt <= frame_cnt + 1`, wrapping modulo 2^16.
- `switch` and `increment` in the same cycle: `switch` wins and the increment is discarded. An increment that would overflow still marks the finishing frame `done_ovf=1`.
- Wrap-around: index `NUM_BUFS-1` is followed by index 0 at `BASE_ADDR`.
- Arithmetic: all address math is unsigned `ADDR_W`. The team guarantees `BASE_ADDR + NUM_BUFS*BUF_STRIDE ≤ 2^ADDR_W`, so no modular wrap occurs.

## Timing
- Reset values (async assert, sync release): `addr=BASE_ADDR`, `buf_idx=0`, `done_idx=NUM_BUFS-1`, `done_valid=0`, `done_ovf=0`, `frame_cnt=0`, internal `ovf=0`.
- Reset asserted mid-frame clears everything immediately. No `done_valid` is produced for the aborted frame.
- Latency: 1 cycle. A strobe sampled at edge k is visible on outputs after edge k.
- `increment` and `switch` are level-sampled every cycle. Back-to-back strobes are legal, with one action per cycle.
- `done_valid` is high for exactly the cycle after a `switch` and never two cycles in a row unless `switch` is high on consecutive cycles.
- `rd_lock`/`rd_idx` are sampled only in the cycle `switch` is high.

## Configuration
- `FRAME_ADDR_GEN_READ_LOCK_EN` defined:
  - If `rd_lock=1` and `nxt==rd_idx` at `switch`, then `nxt` becomes `(nxt+1) mod NUM_BUFS`.
  - The skipped buffer keeps its contents; `done_*` reporting is unchanged.
- Not defined: `rd_lock` and `rd_idx` are present but ignored, and rotation is strictly sequential.

## Test plan
- Reset, then 3× `increment` → `addr` = 0x0F80_0000, 0x0F80_0004, 0x0F80_0008, 0x0F80_000C; `buf_idx=0`.
- 4× `switch` from reset → `buf_idx` 1,2,3,0; `addr` 0x0FC0_0000, 0x1000_0000, 0x1040_0000, 0x0F80_0000; `done_idx` 0,1,2,3 with `done_valid` pulses; `frame_cnt=4`.
- 0x100000 increments in buffer 0 → `addr` stalls at 0x0FBF_FFFC; then `switch` → `done_ovf=1`, `done_idx=0`; next frame reports `done_ovf=0`.
- `switch` and `increment` in the same cycle at `buf_idx=1` → `addr`=0x1000_0000 exactly (increment dropped).
- `FRAME_ADDR_GEN_READ_LOCK_EN`, `rd_lock=1`, `rd_idx=1`, `switch` at `buf_idx=0` → `buf_idx=2`, `addr`=0x1000_0000; with macro undefined → `buf_idx=1`.
- `sys_rst_n` low mid-frame with `addr`=0x1040_0010 → outputs return to reset values asynchronously with no `done_valid`; after 0xFFFF+1 switches, `frame_cnt` wraps to 0.
